// File: rtl/rca_wb_sequencer_if.sv
// rca_wb_sequencer_if: single-entry unit writeback bus (done/ack handshake)
interface rca_wb_sequencer_if #(
  parameter int XLEN = 32,
  parameter int ID_W = 3
);
  logic            wb_done;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [ID_W-1:0] wb_id;
  logic            wb_ack;
  modport master(output wb_done, wb_rd, wb_data, wb_id, input wb_ack);
  modport slave(input wb_done, wb_rd, wb_data, wb_id, output wb_ack);
endinterface

// File: rtl/rca_wb_sequencer.sv
// rca_wb_sequencer: serialises committed RCA grid results onto the unit writeback bus
// Optional: define RCA_WB_BYPASS_EN to present the first beat in the commit cycle.
module rca_wb_sequencer #(
  parameter int XLEN            = 32,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int ID_W            = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [ID_W-1:0]              issue_id,
  input  logic [5*NUM_WRITE_PORTS-1:0] issue_rd,
  input  logic [NUM_WRITE_PORTS-1:0]   issue_we,
  input  logic [XLEN*NUM_WRITE_PORTS-1:0] grid_data,
  input  logic                         grid_committing,
  output logic                         grid_consume,
  rca_wb_sequencer_if.master           wb,
  output logic                         instr_complete,
  output logic                         busy
);
  localparam int N  = NUM_WRITE_PORTS;
  localparam int PW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_DATA, DRAIN} state_t;
  state_t          state, state_n;
  logic [N-1:0]    mask_q, mask_n, eff_mask, clr_mask;
  logic [5*N-1:0]  rd_q;
  logic [ID_W-1:0] id_q;
  logic [XLEN-1:0] data_q [N];
  logic [PW-1:0]   ptr;
  logic            done, leave, complete_q;
  always_comb begin
    eff_mask = '0;
    for (int i = 0; i < N; i++) eff_mask[i] = issue_we[i] && (issue_rd[5*i +: 5] != 5'd0);
  end
  // ptr always names the lowest pending port; beats leave in ascending port order
  always_comb begin
    ptr = '0;
    for (int i = N - 1; i >= 0; i--) if (mask_q[i]) ptr = PW'(i);
  end
  assign clr_mask = mask_q & ~(N'(1) << ptr);
  always_comb begin
    state_n      = state;
    mask_n       = mask_q;
    grid_consume = 1'b0;
    done         = 1'b0;
    leave        = 1'b0;
    case (state)
      IDLE: if (issue_valid) begin
        state_n = WAIT_DATA;
        mask_n  = eff_mask;
      end
      WAIT_DATA: if (grid_committing) begin
        grid_consume = 1'b1;
`ifdef RCA_WB_BYPASS_EN
        done = |mask_q;
        if (done && wb.wb_ack) mask_n = clr_mask;
`endif
        leave   = ~|mask_n;
        state_n = leave ? IDLE : DRAIN;
      end
      DRAIN: begin
        done = 1'b1;
        if (wb.wb_ack) mask_n = clr_mask;
        leave   = ~|mask_n;
        state_n = leave ? IDLE : DRAIN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mask_q     <= '0;
      rd_q       <= '0;
      id_q       <= '0;
      complete_q <= 1'b0;
      for (int i = 0; i < N; i++) data_q[i] <= '0;
    end else begin
      state      <= state_n;
      mask_q     <= mask_n;
      complete_q <= leave;
      if (state == IDLE && issue_valid) begin
        rd_q <= issue_rd;
        id_q <= issue_id;
      end
      if (grid_consume) for (int i = 0; i < N; i++) data_q[i] <= grid_data[XLEN*i +: XLEN];
    end
  end
  assign issue_ready    = state == IDLE;
  assign busy           = state != IDLE;
  assign instr_complete = complete_q;
  assign wb.wb_done     = done;
  assign wb.wb_rd       = done ? rd_q[5*ptr +: 5] : 5'd0;
  assign wb.wb_id       = done ? id_q : '0;
  // only the bypass beat is ever presented while still in WAIT_DATA
  assign wb.wb_data     = !done ? '0 : state == WAIT_DATA ? grid_data[XLEN*ptr +: XLEN] : data_q[ptr];
endmodule

// File: doc/rca_wb_sequencer.md
Name: rca_wb_sequencer

Overview:
- Sits directly downstream of the RCA grid writeback stage. Consumes its per-write-port result vector and its all-ports-ready commit flag.
- Holds one issued RCA instruction's destination descriptor and captures the grid results when they commit.
- Serialises the results onto the core's single-entry unit writeback interface (done/ack handshake), one register per accepted beat.
- Signals instruction completion to issue logic.

Parameters:
- XLEN, 32, data width.
- NUM_WRITE_PORTS, 2, grid result ports per RCA instruction (1..8).
- ID_W, 3, instruction id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  descriptor offered
- issue_ready  out  1  sequencer can accept a descriptor
- issue_id  in  ID_W  instruction id
- issue_rd  in  5*NUM_WRITE_PORTS  destination register per port, port i at [5i+4:5i]
- issue_we  in  NUM_WRITE_PORTS  per-port write enable mask
- grid_data  in  XLEN*NUM_WRITE_PORTS  grid result per port
- grid_committing  in  1  all selected grid ports valid
- grid_consume  out  1  pulse: results taken, grid may advance
- wb_done  out  1  writeback beat valid
- wb_rd  out  5  beat destination register
- wb_data  out  XLEN  beat data
- wb_id  out  ID_W  beat instruction id
- wb_ack  in  1  core accepted beat
- instr_complete  out  1  pulse: all beats for the instruction accepted
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state=IDLE; all outputs 0 except issue_ready=1; descriptor and data registers cleared. Reset mid-operation drops the in-flight instruction silently, with no instr_complete.
- States: IDLE, WAIT_DATA, DRAIN.
- IDLE: issue_ready=1. On issue_valid:
  - Latch id, rd, and effective mask = issue_we with bits whose rd==0 cleared (x0 writes suppressed).
  - Go to WAIT_DATA.
- WAIT_DATA: issue_ready=0. On grid_committing:
  - Register all grid_data into the capture buffer.
  - Pulse grid_consume for exactly 1 cycle.
  - If effective mask==0: pulse instr_complete next cycle and return to IDLE.
  - Otherwise go to DRAIN, pointer = lowest set mask bit.
- DRAIN:
  - wb_done=1; wb_rd/wb_data/wb_id come from the pointer entry, registered and stable while wb_done && !wb_ack.
  - On wb_ack: clear the pointer's mask bit and advance to the next set bit (priority encode, ascending).
  - If no bits remain: wb_done drops next cycle, instr_complete pulses for 1 cycle, state=IDLE.
- Latency (macro off):
  - grid_committing at cycle T gives grid_consume at T and wb_done at T+1.
  - With ack every cycle, a k-beat instruction completes at T+k+1.
- issue_valid ignored outside IDLE. grid_committing ignored outside WAIT_DATA (grid_consume stays 0).
- instr_complete and a new issue in the same cycle are legal. issue_ready is high in the cycle the FSM re-enters IDLE, not earlier.
- wb_ack without wb_done: ignored.

Optional Feature:
- Macro: RCA_WB_BYPASS_EN.
- Defined: in WAIT_DATA, when grid_committing=1 and mask!=0, wb_done is asserted combinationally the same cycle. wb_data is taken directly from grid_data at the lowest set bit. If wb_ack arrives that cycle, the beat counts as accepted and is removed from the mask before entering DRAIN. Latency with back-to-back ack is k cycles.
- Undefined: purely registered outputs, latency as above.

Test Plan:
- Reset check: rst_n low mid-DRAIN → wb_done=0, issue_ready=1 immediately, no instr_complete pulse after release.
- Two-port, both ports written: issue rd={5,7}, we=2'b11, id=3. grid_committing with data {0xAAAA0001, 0xBBBB0002}, wb_ack held 1 → beats (rd5,0xAAAA0001,id3), (rd7,0xBBBB0002,id3) on consecutive cycles; instr_complete one cycle after the second ack.
- x0 suppression: rd={0,9}, we=2'b11 → single beat rd9 only. rd={0,0} → no beats; instr_complete one cycle after grid_consume.
- Backpressure: wb_ack=0 for 4 cycles → wb_rd/wb_data/wb_id stable. Ack on cycle 5 advances to the next beat.
- Ignored inputs: issue_valid during DRAIN and grid_committing during IDLE → no state change, grid_consume=0.
- With RCA_WB_BYPASS_EN: ack tied 1, 2 beats → first beat visible in the grid_committing cycle; instr_complete 2 cycles later.
